// File: rtl/control_sequencer_pkg.sv
// rtl/control_sequencer_pkg.sv - control_pkg: opcodes, states, datapath codes and the control bundle
package control_pkg;

    localparam logic [5:0] HLT_OPCODE_DEFAULT = 6'h3F;
    localparam int         T_WIDTH            = 3;

    localparam logic [5:0] OP_BRA = 6'h00;
    localparam logic [5:0] OP_BNE = 6'h01;
    localparam logic [5:0] OP_BEQ = 6'h02;
    localparam logic [5:0] OP_LDI = 6'h03;
    localparam logic [5:0] OP_LD  = 6'h04;
    localparam logic [5:0] OP_ST  = 6'h05;
    localparam logic [5:0] OP_MOV = 6'h06;
    localparam logic [5:0] OP_ADD = 6'h07;
    localparam logic [5:0] OP_AND = 6'h08;
    localparam logic [5:0] OP_INC = 6'h09;

    typedef enum logic [T_WIDTH-1:0] {
        IDLE = 3'd0,
        T0   = 3'd1,
        T1   = 3'd2,
        T2   = 3'd3,
        T3   = 3'd4,
        HALT = 3'd5
    } state_t;

    localparam logic [2:0] FUN_DEC   = 3'b000;
    localparam logic [2:0] FUN_INC   = 3'b001;
    localparam logic [2:0] FUN_LOAD  = 3'b010;
    localparam logic [2:0] FUN_CLEAR = 3'b011;

    localparam logic [4:0] ALU_PASS_A = 5'b10000;
    localparam logic [4:0] ALU_ADD    = 5'b10100;
    localparam logic [4:0] ALU_AND    = 5'b10111;

    localparam logic [1:0] MUX_ALU  = 2'b00;
    localparam logic [1:0] MUX_OUTC = 2'b01;
    localparam logic [1:0] MUX_MEM  = 2'b10;
    localparam logic [1:0] MUX_IR   = 2'b11;

    localparam logic [1:0] ARF_PC = 2'b00;
    localparam logic [1:0] ARF_AR = 2'b10;
    localparam logic [1:0] ARF_SP = 2'b11;

    // Active-low enables: a 0 bit selects the register.
    localparam logic [2:0] ARF_EN_NONE = 3'b111;
    localparam logic [2:0] ARF_EN_PC   = 3'b011;
    localparam logic [2:0] ARF_EN_AR   = 3'b101;
    localparam logic [3:0] RF_EN_NONE  = 4'b1111;

    typedef struct packed {
        logic [2:0] rf_outa_sel;
        logic [2:0] rf_outb_sel;
        logic [2:0] rf_fun_sel;
        logic [3:0] rf_reg_sel;
        logic [3:0] rf_scr_sel;
        logic [4:0] alu_fun_sel;
        logic       alu_wf;
        logic [1:0] mux_a_sel;
        logic [1:0] mux_b_sel;
        logic       mux_c_sel;
        logic [1:0] arf_outc_sel;
        logic [1:0] arf_outd_sel;
        logic [2:0] arf_fun_sel;
        logic [2:0] arf_reg_sel;
        logic       ir_lh;
        logic       ir_write;
        logic       mem_wr;
        logic       mem_cs;
        logic       halted;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        rf_outa_sel:  3'b000,
        rf_outb_sel:  3'b000,
        rf_fun_sel:   FUN_DEC,
        rf_reg_sel:   RF_EN_NONE,
        rf_scr_sel:   RF_EN_NONE,
        alu_fun_sel:  5'b00000,
        alu_wf:       1'b0,
        mux_a_sel:    MUX_ALU,
        mux_b_sel:    MUX_ALU,
        mux_c_sel:    1'b0,
        arf_outc_sel: ARF_PC,
        arf_outd_sel: ARF_PC,
        arf_fun_sel:  FUN_DEC,
        arf_reg_sel:  ARF_EN_NONE,
        ir_lh:        1'b0,
        ir_write:     1'b0,
        mem_wr:       1'b0,
        mem_cs:       1'b1,
        halted:       1'b0
    };

    // Active-low one-cold write enable {R1,R2,R3,R4} for a 2-bit register field.
    function automatic logic [3:0] rf_en(input logic [1:0] r);
        return ~(4'b1000 >> r);
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - control/datapath bundle between sequencer and ALU system
interface control_sequencer_if;
    logic [15:0] IROut;
    logic [3:0]  Flags;
    logic [2:0]  RF_OutASel;
    logic [2:0]  RF_OutBSel;
    logic [2:0]  RF_FunSel;
    logic [3:0]  RF_RegSel;
    logic [3:0]  RF_ScrSel;
    logic [4:0]  ALU_FunSel;
    logic        ALU_WF;
    logic [1:0]  MuxASel;
    logic [1:0]  MuxBSel;
    logic        MuxCSel;
    logic [1:0]  ARF_OutCSel;
    logic [1:0]  ARF_OutDSel;
    logic [2:0]  ARF_FunSel;
    logic [2:0]  ARF_RegSel;
    logic        IR_LH;
    logic        IR_Write;
    logic        Mem_WR;
    logic        Mem_CS;
    logic        Halted;

    modport master (
        input  IROut, Flags,
        output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
               ALU_FunSel, ALU_WF, MuxASel, MuxBSel, MuxCSel,
               ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
               IR_LH, IR_Write, Mem_WR, Mem_CS, Halted
    );

    modport slave (
        output IROut, Flags,
        input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
               ALU_FunSel, ALU_WF, MuxASel, MuxBSel, MuxCSel,
               ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
               IR_LH, IR_Write, Mem_WR, Mem_CS, Halted
    );
endinterface

// File: rtl/control_sequencer_decoder.sv
// rtl/control_sequencer_decoder.sv - control_decoder: (state, IROut, Flags) -> control bundle
module control_decoder
    import control_pkg::*;
(
    input  state_t      state,
    input  logic [15:0] ir,
    input  logic [3:0]  flags,
    output ctrl_t       ctrl
);

    logic [5:0] opcode;
    logic [1:0] rx;
    logic [1:0] dst;
    logic [1:0] sreg1;
    logic [1:0] sreg2;
    logic       zero;
    logic       unused_bits;

    assign opcode      = ir[15:10];
    assign rx          = ir[9:8];
    assign dst         = ir[7:6];
    assign sreg1       = ir[5:4];
    assign sreg2       = ir[3:2];
    assign zero        = flags[3];
    // VALUE bits travel straight through MuxB/MuxA; C, N, O are not consumed here.
    assign unused_bits = ^{ir[1:0], flags[2:0]};

    // Map the current step and instruction onto datapath selects and enables.
    always_comb begin
        ctrl = CTRL_IDLE;
        case (state)
            T0, T1: begin
                ctrl.arf_outd_sel = ARF_PC;
                ctrl.mem_cs       = 1'b0;
                ctrl.ir_write     = 1'b1;
                ctrl.ir_lh        = (state == T1);
                ctrl.arf_reg_sel  = ARF_EN_PC;
                ctrl.arf_fun_sel  = FUN_INC;
            end
            T2: begin
                case (opcode)
                    OP_BRA, OP_BNE, OP_BEQ: begin
                        if ((opcode == OP_BRA) ||
                            (opcode == OP_BNE && !zero) ||
                            (opcode == OP_BEQ && zero)) begin
                            ctrl.mux_b_sel   = MUX_IR;
                            ctrl.arf_fun_sel = FUN_LOAD;
                            ctrl.arf_reg_sel = ARF_EN_PC;
                        end
                    end
                    OP_LDI: begin
                        ctrl.mux_a_sel  = MUX_IR;
                        ctrl.rf_fun_sel = FUN_LOAD;
                        ctrl.rf_reg_sel = rf_en(rx);
                    end
                    OP_LD, OP_ST: begin
                        ctrl.mux_b_sel   = MUX_IR;
                        ctrl.arf_fun_sel = FUN_LOAD;
                        ctrl.arf_reg_sel = ARF_EN_AR;
                    end
                    OP_MOV, OP_INC: begin
                        ctrl.rf_outa_sel = {1'b0, sreg1};
                        ctrl.alu_fun_sel = ALU_PASS_A;
                        ctrl.mux_a_sel   = MUX_ALU;
                        ctrl.rf_fun_sel  = FUN_LOAD;
                        ctrl.rf_reg_sel  = rf_en(dst);
                    end
                    OP_ADD, OP_AND: begin
                        ctrl.rf_outa_sel = {1'b0, sreg1};
                        ctrl.rf_outb_sel = {1'b0, sreg2};
                        ctrl.alu_fun_sel = (opcode == OP_ADD) ? ALU_ADD : ALU_AND;
                        ctrl.alu_wf      = ir[9];
                        ctrl.mux_a_sel   = MUX_ALU;
                        ctrl.rf_fun_sel  = FUN_LOAD;
                        ctrl.rf_reg_sel  = rf_en(dst);
                    end
                    default: ;
                endcase
            end
            T3: begin
                case (opcode)
                    OP_LD: begin
                        ctrl.arf_outd_sel = ARF_AR;
                        ctrl.mem_cs       = 1'b0;
                        ctrl.mux_a_sel    = MUX_MEM;
                        ctrl.rf_fun_sel   = FUN_LOAD;
                        ctrl.rf_reg_sel   = rf_en(rx);
                    end
                    OP_ST: begin
                        ctrl.rf_outa_sel  = {1'b0, rx};
                        ctrl.alu_fun_sel  = ALU_PASS_A;
                        ctrl.mux_c_sel    = 1'b0;
                        ctrl.arf_outd_sel = ARF_AR;
                        ctrl.mem_cs       = 1'b0;
                        ctrl.mem_wr       = 1'b1;
                    end
                    OP_INC: begin
                        ctrl.rf_fun_sel = FUN_INC;
                        ctrl.rf_reg_sel = rf_en(dst);
                    end
                    default: ;
                endcase
            end
            HALT: ctrl.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired sequencer top; optional RETIRE_CNT_EN adds Retired counter
module control_sequencer
    import control_pkg::*;
#(
    parameter logic [5:0] HLT_OPCODE = HLT_OPCODE_DEFAULT
) (
    input  logic                 Clock,
    input  logic                 Reset,
    control_sequencer_if.master  bus
`ifdef RETIRE_CNT_EN
    ,
    output logic [15:0]          Retired
`endif
);

    state_t     state;
    state_t     state_nxt;
    ctrl_t      ctrl;
    logic [5:0] opcode;

    assign opcode = bus.IROut[15:10];

    // Sequence-counter register; reset aborts whatever instruction is in flight.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Step order: two fetch cycles, T2 execute, T3 only for LD/ST/INC, HALT sticks.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = T0;
            T0:   state_nxt = T1;
            T1:   state_nxt = T2;
            T2: begin
                if (opcode == HLT_OPCODE) begin
                    state_nxt = HALT;
                end else if (opcode == OP_LD || opcode == OP_ST || opcode == OP_INC) begin
                    state_nxt = T3;
                end else begin
                    state_nxt = T0;
                end
            end
            T3:   state_nxt = T0;
            HALT: state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    control_decoder u_decoder (
        .state (state),
        .ir    (bus.IROut),
        .flags (bus.Flags),
        .ctrl  (ctrl)
    );

    assign bus.RF_OutASel  = ctrl.rf_outa_sel;
    assign bus.RF_OutBSel  = ctrl.rf_outb_sel;
    assign bus.RF_FunSel   = ctrl.rf_fun_sel;
    assign bus.RF_RegSel   = ctrl.rf_reg_sel;
    assign bus.RF_ScrSel   = ctrl.rf_scr_sel;
    assign bus.ALU_FunSel  = ctrl.alu_fun_sel;
    assign bus.ALU_WF      = ctrl.alu_wf;
    assign bus.MuxASel     = ctrl.mux_a_sel;
    assign bus.MuxBSel     = ctrl.mux_b_sel;
    assign bus.MuxCSel     = ctrl.mux_c_sel;
    assign bus.ARF_OutCSel = ctrl.arf_outc_sel;
    assign bus.ARF_OutDSel = ctrl.arf_outd_sel;
    assign bus.ARF_FunSel  = ctrl.arf_fun_sel;
    assign bus.ARF_RegSel  = ctrl.arf_reg_sel;
    assign bus.IR_LH       = ctrl.ir_lh;
    assign bus.IR_Write    = ctrl.ir_write;
    assign bus.Mem_WR      = ctrl.mem_wr;
    assign bus.Mem_CS      = ctrl.mem_cs;
    assign bus.Halted      = ctrl.halted;

`ifdef RETIRE_CNT_EN
    logic [15:0] retired_q;

    // Count instructions completing an execute step and returning to fetch.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            retired_q <= 16'd0;
        end else if (state_nxt == T0 && (state == T2 || state == T3)) begin
            retired_q <= retired_q + 16'd1;
        end
    end

    assign Retired = retired_q;
`endif

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Hardwired control unit that drives the ALU-system datapath: register file (RF), address register file (ARF), ALU, memory, instruction register (IR), MuxA, MuxB and MuxC.
- Sequence-counter FSM: two-cycle fetch (IR low byte, then high byte), then decode/execute over T2..T3.
- Consumes only IROut and ALU Flags; produces every datapath select/enable; issues one memory access per cycle at most.

Parameters:
HLT_OPCODE, 6'h3F, opcode that halts the sequencer until reset
T_WIDTH, 3, width of sequence counter (states T0..T3 plus IDLE/HALT encodings)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
IROut  in  16  IR contents; [15:10] opcode
Flags  in  4  ALU flags {Z,C,N,O}, Z=Flags[3]
RF_OutASel  out  3  RF port A select (000..011 R1..R4)
RF_OutBSel  out  3  RF port B select
RF_FunSel  out  3  RF function
RF_RegSel  out  4  RF write enables {R1,R2,R3,R4}, active-low
RF_ScrSel  out  4  scratch enables, active-low; always 4'b1111
ALU_FunSel  out  5  ALU function
ALU_WF  out  1  ALU flag write enable
MuxASel  out  2  00 ALUOut, 01 OutC, 10 MemOut, 11 IROut[7:0]
MuxBSel  out  2  same encoding as MuxASel
MuxCSel  out  1  0 ALUOut[7:0], 1 ALUOut[15:8]
ARF_OutCSel  out  2  00 PC, 10 AR, 11 SP
ARF_OutDSel  out  2  memory address source, same encoding
ARF_FunSel  out  3  ARF function
ARF_RegSel  out  3  enables {PC,AR,SP}, active-low
IR_LH  out  1  0 load IR[7:0], 1 load IR[15:8]
IR_Write  out  1  IR load enable
Mem_WR  out  1  1 write, 0 read
Mem_CS  out  1  chip select, active-low
Halted  out  1  high while in HALT

Behaviour:
- Reset low (async): state=IDLE; all outputs idle.
- Idle output values: RF_RegSel=1111, RF_ScrSel=1111, ARF_RegSel=111, IR_Write=0, ALU_WF=0, Mem_CS=1, Mem_WR=0, Halted=0, all selects 0.
- Outputs are combinational from registered state, IROut and Flags.
- IDLE -> T0 on the first clock after reset release.
- FunSel codes: 000 decrement, 001 increment, 010 load, 011 clear.
- ALU codes: 10000 pass A, 10100 A+B, 10111 A AND B (all 16-bit).
- Memory read is combinational; MemOut is valid in the same cycle.
- T0: OutDSel=PC, Mem_CS=0, IR_Write=1, IR_LH=0; PC incremented (ARF_RegSel=011, FunSel=001).
- T1: same as T0 with IR_LH=1. IROut is valid from T2.
- Address format: [9:8] Rx (R1..R4), [7:0] VALUE.
- Register format: [9] S (drives ALU_WF), [7:6] DST, [5:4] SREG1, [3:2] SREG2.
- 00 BRA: T2 PC<-VALUE (MuxB=11, load) -> T0.
- 01 BNE: PC load only if Z=0. 02 BEQ: only if Z=1. Flags are sampled in T2.
- 03 LDI: T2 Rx<-VALUE (MuxA=11) -> T0.
- 04 LD: T2 AR<-VALUE; T3 Rx<-MemOut (OutD=AR, MuxA=10, Mem_CS=0) -> T0.
- 05 ST: T2 AR<-VALUE; T3 OutA=Rx, ALU pass A, MuxC=0, Mem_CS=0, Mem_WR=1 -> T0.
- 06 MOV: T2 DST<-SREG1 via ALU pass A (MuxA=00) -> T0.
- 07 ADD, 08 AND: T2 DST<-SREG1 op SREG2; ALU_WF=S -> T0.
- 09 INC: T2 DST<-SREG1; T3 DST increment. DST==SREG1 is legal -> T0.
- HLT_OPCODE: enter HALT; Halted=1; outputs idle; exit only via reset.
- Undefined opcodes execute as NOP: T2 drives idle outputs -> T0.
- PC wraps 16'hFFFF->0 inside the ARF; the sequencer takes no action.
- Reset mid-instruction aborts immediately. Partially updated datapath registers are not restored.
- Never assert Mem_WR with Mem_CS=1. Never assert IR_Write outside T0/T1.

Optional Feature:
RETIRE_CNT_EN:
- Defined: adds output Retired[15:0]. Reset 0; +1 on each transition back to T0 from an execute state (NOP included); wraps at 16'hFFFF.
- Undefined: port and counter are absent; behaviour otherwise identical.

Decomposition:
- Package control_pkg: opcode constants, state enum (IDLE,T0,T1,T2,T3,HALT), FunSel/ALU codes, select encodings, active-low enable constants.
- One sub-module, control_decoder: combinational map (state, IROut, Flags) -> output bundle. The top holds only state and counter registers.

Test Plan:
- Reset low mid-T3 of ST -> next edge region: Mem_CS=1, Mem_WR=0, state IDLE; release -> IDLE then T0.
- mem[0]=8'h07, mem[1]=8'h0C (LDI R1,7) -> T0/T1 IR_LH 0/1, PC 0->2; T2 RF_RegSel=0111, MuxASel=11; R1=7.
- R1=3, R2=4, ADD S=1 DST=R3 -> T2 ALU_FunSel=10100, ALU_WF=1; R3=7; back to T0 after 3 cycles.
- Z=1 with BNE 8'h40 -> PC unchanged; Z=0 -> PC=16'h0040 after T2.
- ST R2=16'h00A5 to 8'h80 -> T3 OutDSel=10, Mem_WR=1, mem[0x80]=8'hA5; LD R4 from 8'h80 -> R4=16'h00A5.
- Opcode 3F -> Halted=1, outputs idle for 100 cycles; undefined opcode 2A -> 3-cycle NOP; Retired +1 when RETIRE_CNT_EN is defined.
